// File: rtl/combo_checker.sv
// Digit-entry combination lock: compares BCD digits against a stored code, opens on a match,
// forces a timed lockout after repeated failures, and allows reprogramming while open.
module combo_checker #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_in,
  input  logic       digit_valid,
  input  logic       clear,
  input  logic       program_en,
  input  logic       relock,
  output logic       unlocked,
  output logic       locked_out,
  output logic       match_pulse,
  output logic       fail_pulse,
  output logic [3:0] entry_count,
  output logic [3:0] tries_left,
  output logic [6:0] Digit0
);

  localparam int unsigned PosW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = $clog2(LOCKOUT_CYCLES);

  localparam logic [3:0]      TriesInit = 4'(MAX_TRIES);
  localparam logic [3:0]      LastPos   = 4'(DIGITS - 1);
  localparam logic [CntW-1:0] CntInit   = CntW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {StEntry, StOpen, StLockout} state_e;

  state_e                   state_q, state_d;
  logic [DIGITS-1:0][3:0]   code_q, code_d;
  logic [3:0]               pos_q, pos_d;
  logic                     mismatch_q, mismatch_d;
  logic [3:0]               tries_q, tries_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     match_q, match_d;
  logic                     fail_q, fail_d;
  logic                     unlocked_q, unlocked_d;
  logic                     locked_q, locked_d;

  logic             digit_ok;
  logic [PosW-1:0]  idx;
  logic             mismatch_nx;

  assign digit_ok    = digit_valid && (digit_in <= 4'd9);
  assign idx         = pos_q[PosW-1:0];
  assign mismatch_nx = mismatch_q | (digit_in != code_q[idx]);

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pos_d      = pos_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    cnt_d      = cnt_q;
    match_d    = 1'b0;
    fail_d     = 1'b0;

    case (state_q)
      StEntry: begin
        if (clear) begin
          pos_d      = 4'd0;
          mismatch_d = 1'b0;
        end else if (digit_ok) begin
          if (pos_q != LastPos) begin
            pos_d      = pos_q + 4'd1;
            mismatch_d = mismatch_nx;
          end else begin
            pos_d      = 4'd0;
            mismatch_d = 1'b0;
            if (!mismatch_nx) begin
              match_d = 1'b1;
              state_d = StOpen;
              tries_d = TriesInit;
            end else begin
              fail_d = 1'b1;
              if (tries_q > 4'd1) begin
                tries_d = tries_q - 4'd1;
              end else begin
                tries_d = 4'd0;
                state_d = StLockout;
                cnt_d   = CntInit;
              end
            end
          end
        end
      end
      StOpen: begin
        if (relock) begin
          pos_d   = 4'd0;
          state_d = StEntry;
        end else if (clear) begin
          pos_d = 4'd0;
        end else if (program_en && digit_ok) begin
          code_d[idx] = digit_in;
          pos_d       = (pos_q == LastPos) ? 4'd0 : pos_q + 4'd1;
        end
      end
      StLockout: begin
        if (cnt_q == '0) begin
          state_d = StEntry;
          tries_d = TriesInit;
          pos_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StEntry;
    endcase

    unlocked_d = (state_d == StOpen);
    locked_d   = (state_d == StLockout);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEntry;
      code_q     <= '0;
      pos_q      <= 4'd0;
      mismatch_q <= 1'b0;
      tries_q    <= TriesInit;
      cnt_q      <= '0;
      match_q    <= 1'b0;
      fail_q     <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      pos_q      <= pos_d;
      mismatch_q <= mismatch_d;
      tries_q    <= tries_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      locked_q   <= locked_d;
    end
  end

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_q;
  assign match_pulse = match_q;
  assign fail_pulse  = fail_q;
  assign entry_count = pos_q;
  assign tries_left  = tries_q;

  // Active-high segments, bit order gfedcba; non-decimal values blank the digit.
  always_comb begin
    Digit0 = 7'h00;
    case (tries_q)
      4'd0:    Digit0 = 7'h3F;
      4'd1:    Digit0 = 7'h06;
      4'd2:    Digit0 = 7'h5B;
      4'd3:    Digit0 = 7'h4F;
      4'd4:    Digit0 = 7'h66;
      4'd5:    Digit0 = 7'h6D;
      4'd6:    Digit0 = 7'h7D;
      4'd7:    Digit0 = 7'h07;
      4'd8:    Digit0 = 7'h7F;
      4'd9:    Digit0 = 7'h6F;
      default: Digit0 = 7'h00;
    endcase
  end

endmodule

// File: tb/tb_combo_checker.sv
// Directed bench for combo_checker with a short lockout so the full lockout window is observable.
module tb_combo_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic       program_en;
  logic       relock;
  logic       unlocked;
  logic       locked_out;
  logic       match_pulse;
  logic       fail_pulse;
  logic [3:0] entry_count;
  logic [3:0] tries_left;
  logic [6:0] Digit0;

  int checks = 0;
  int errors = 0;

  combo_checker #(
    .DIGITS        (4),
    .MAX_TRIES     (3),
    .LOCKOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .clear      (clear),
    .program_en (program_en),
    .relock     (relock),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .match_pulse(match_pulse),
    .fail_pulse (fail_pulse),
    .entry_count(entry_count),
    .tries_left (tries_left),
    .Digit0     (Digit0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  // Four BCD digits, most significant nibble entered first.
  task automatic enter_code(input logic [15:0] c);
    for (int i = 0; i < 4; i++) send_digit(c[15-4*i -: 4]);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] good;
    reset = 1'b1; digit_in = 4'd0; digit_valid = 1'b0;
    clear = 1'b0; program_en = 1'b0; relock = 1'b0;
    tick(); tick();
    reset = 1'b0;

    check("rst_unlocked", unlocked, 0);
    check("rst_locked", locked_out, 0);
    check("rst_match", match_pulse, 0);
    check("rst_fail", fail_pulse, 0);
    check("rst_entry", entry_count, 0);
    check("rst_tries", tries_left, 3);
    check("rst_seg", Digit0, 7'h4F);

    // Default code is all zeros.
    enter_code(16'h0000);
    check("open_match", match_pulse, 1);
    check("open_unlocked", unlocked, 1);
    check("open_tries", tries_left, 3);
    check("open_seg", Digit0, 7'h4F);
    tick();
    check("open_match_1cyc", match_pulse, 0);
    check("open_stays", unlocked, 1);

    // Program 1984 while open.
    program_en = 1'b1;
    send_digit(4'd1); send_digit(4'd9);
    check("prog_count", entry_count, 2);
    send_digit(4'd8); send_digit(4'd4);
    check("prog_wrap", entry_count, 0);
    program_en = 1'b0;
    do_relock();
    check("relock_unlocked", unlocked, 0);

    enter_code(16'h0000);
    check("old_code_fail", fail_pulse, 1);
    check("old_code_tries", tries_left, 2);
    check("old_code_seg", Digit0, 7'h5B);
    enter_code(16'h1984);
    check("new_code_match", match_pulse, 1);
    check("new_code_unlocked", unlocked, 1);
    check("new_code_tries", tries_left, 3);
    do_relock();

    enter_code(16'h1985);
    check("bad_fail", fail_pulse, 1);
    check("bad_tries", tries_left, 2);
    check("bad_entry", entry_count, 0);
    check("bad_unlocked", unlocked, 0);
    tick();
    check("bad_fail_1cyc", fail_pulse, 0);

    // Non-BCD digit dropped; clear beats a simultaneous digit.
    send_digit(4'd1);
    send_digit(4'hA);
    check("nonbcd_entry", entry_count, 1);
    send_digit(4'd9);
    check("two_digits", entry_count, 2);
    clear = 1'b1;
    send_digit(4'd8);
    clear = 1'b0;
    check("clear_entry", entry_count, 0);
    check("clear_tries", tries_left, 2);
    enter_code(16'h1984);
    check("after_clear_match", match_pulse, 1);
    check("after_clear_tries", tries_left, 3);
    do_relock();

    // Lockout window: correct digits fed throughout must be ignored.
    enter_code(16'h0000);
    enter_code(16'h0000);
    check("lk_tries1", tries_left, 1);
    enter_code(16'h0000);
    check("lk_fail", fail_pulse, 1);
    check("lk_locked", locked_out, 1);
    check("lk_tries0", tries_left, 0);
    check("lk_seg", Digit0, 7'h3F);
    good = 16'h1984;
    n = 0;
    while (locked_out && n < 20) begin
      digit_in    = good[15-4*(n%4) -: 4];
      digit_valid = 1'b1;
      tick();
      n++;
    end
    digit_valid = 1'b0;
    check("lk_cycles", n, 8);
    check("lk_end_tries", tries_left, 3);
    check("lk_end_entry", entry_count, 0);
    check("lk_end_unlocked", unlocked, 0);
    enter_code(16'h1984);
    check("lk_end_match", match_pulse, 1);
    check("lk_end_open", unlocked, 1);
    do_relock();

    // Reset mid-lockout restores the zero code.
    enter_code(16'h0000);
    enter_code(16'h0000);
    enter_code(16'h0000);
    check("lk2_locked", locked_out, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_lk_locked", locked_out, 0);
    check("rst_lk_tries", tries_left, 3);
    check("rst_lk_seg", Digit0, 7'h4F);
    enter_code(16'h0000);
    check("rst_lk_match", match_pulse, 1);
    check("rst_lk_open", unlocked, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
